// File: rtl/btn_debounce.sv
// Pushbutton conditioner: two-flop synchroniser, counter-qualified debounce FSM, registered
// press/release pulses. Optional long-press detector enabled by BTN_DEBOUNCE_LONG_PRESS_EN.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic press,
    // Named release_pulse because release is a reserved word in SystemVerilog.
    output logic release_pulse,
    output logic long_press
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StReleased,
        StWaitPress,
        StPressed,
        StWaitRelease
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= StReleased;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        case (state_q)
            StReleased: begin
                if (sync2_q) begin
                    state_d = StWaitPress;
                    cnt_d   = CntW'(1);
                end
            end
            StWaitPress: begin
                if (!sync2_q) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPressed: begin
                if (!sync2_q) begin
                    state_d = StWaitRelease;
                    cnt_d   = CntW'(1);
                end
            end
            StWaitRelease: begin
                if (sync2_q) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StReleased;
                cnt_d   = '0;
            end
        endcase
    end

    assign btn_level     = level_q;
    assign press         = press_q;
    assign release_pulse = rel_q;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(HOLD_CYCLES);

    logic [HoldW-1:0] hold_q, hold_d;
    logic             long_q, long_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    // Saturates at HoldMax so the pulse fires once per press.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_d) begin
            hold_d = '0;
        end else if ((state_q == StPressed || state_q == StWaitRelease) && hold_q != HoldMax) begin
            hold_d = hold_q + 1'b1;
            if (hold_q == HoldLast && !rel_d) begin
                long_d = 1'b1;
            end
        end
    end

    assign long_press = long_q;
`else
    if (HOLD_CYCLES == 0) begin : g_hold_cycles_illegal
    end

    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed self-checking bench for btn_debounce with default parameters; expectations adapt to
// whether BTN_DEBOUNCE_LONG_PRESS_EN is defined.
module tb_btn_debounce;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    localparam bit LongEn = 1'b1;
`else
    localparam bit LongEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic btn_level;
    logic press;
    logic release_pulse;
    logic long_press;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btn_debounce #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press        (press),
        .release_pulse(release_pulse),
        .long_press   (long_press)
    );

    // Advance one clock edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        btn_in = 1'b0;
        #2;
        checks++;
        if ({btn_level, press, release_pulse, long_press} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async got=%b want=0000",
                     {btn_level, press, release_pulse, long_press});
        end
        step();
        step();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if ({btn_level, press, release_pulse, long_press} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_idle k=%0d got=%b want=0000", k,
                         {btn_level, press, release_pulse, long_press});
            end
        end
    endtask

    task automatic test_press_latency();
        btn_in = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            checks++;
            if (press !== (k == 5)) begin
                errors++;
                $display("FAIL press_latency k=%0d got=%b want=%b", k, press, k == 5);
            end
            checks++;
            if (btn_level !== (k >= 5)) begin
                errors++;
                $display("FAIL level_rise k=%0d got=%b want=%b", k, btn_level, k >= 5);
            end
        end
        btn_in = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            checks++;
            if (release_pulse !== (k == 5) || press !== 1'b0) begin
                errors++;
                $display("FAIL release_latency k=%0d got=%b%b want=%b0", k, release_pulse,
                         press, k == 5);
            end
            checks++;
            if (btn_level !== (k < 5)) begin
                errors++;
                $display("FAIL level_fall k=%0d got=%b want=%b", k, btn_level, k < 5);
            end
        end
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 12; k++) begin
            btn_in = (k < 3);
            step();
            checks++;
            if ({btn_level, press} !== 2'b00) begin
                errors++;
                $display("FAIL glitch_ignored k=%0d got=%b want=00", k, {btn_level, press});
            end
        end
        // Full latency again shows qualification restarted from RELEASED.
        btn_in = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            checks++;
            if (press !== (k == 5)) begin
                errors++;
                $display("FAIL glitch_restart k=%0d got=%b want=%b", k, press, k == 5);
            end
        end
        btn_in = 1'b0;
        for (int k = 0; k < 9; k++) step();
    endtask

    task automatic test_min_width();
        for (int k = 0; k < 12; k++) begin
            btn_in = (k < 4);
            step();
            checks++;
            if ({press, release_pulse, btn_level} !== {k == 5, k == 9, k >= 5 && k < 9}) begin
                errors++;
                $display("FAIL min_width k=%0d got=%b want=%b", k,
                         {press, release_pulse, btn_level}, {k == 5, k == 9, k >= 5 && k < 9});
            end
        end
    endtask

    task automatic test_bounce();
        int rel_count = 0;
        btn_in = 1'b1;
        for (int k = 0; k < 8; k++) step();
        checks++;
        if (btn_level !== 1'b1) begin
            errors++;
            $display("FAIL bounce_setup got=%b want=1", btn_level);
        end
        for (int k = 0; k < 12; k++) begin
            btn_in = (k == 1 || k == 3);
            step();
            if (release_pulse === 1'b1) rel_count++;
            checks++;
            if ({release_pulse, btn_level, press} !== {k == 9, k < 9, 1'b0}) begin
                errors++;
                $display("FAIL bounce k=%0d got=%b want=%b", k,
                         {release_pulse, btn_level, press}, {k == 9, k < 9, 1'b0});
            end
        end
        checks++;
        if (rel_count !== 1) begin
            errors++;
            $display("FAIL bounce_count got=%0d want=1", rel_count);
        end
    endtask

    task automatic test_reset_mid_wait();
        step();
        btn_in = 1'b1;
        for (int k = 0; k < 4; k++) step();
        reset = 1'b0;
        #2;
        checks++;
        if ({btn_level, press, release_pulse, long_press} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_wait got=%b want=0000",
                     {btn_level, press, release_pulse, long_press});
        end
        step();
        step();
        reset = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            checks++;
            if ({press, btn_level} !== {k == 5, k >= 5}) begin
                errors++;
                $display("FAIL reset_requalify k=%0d got=%b want=%b", k, {press, btn_level},
                         {k == 5, k >= 5});
            end
        end
        // Asynchronous clear of an asserted level, between clock edges.
        reset = 1'b0;
        #2;
        checks++;
        if (btn_level !== 1'b0) begin
            errors++;
            $display("FAIL reset_pressed got=%b want=0", btn_level);
        end
        step();
        btn_in = 1'b0;
        reset  = 1'b1;
        for (int k = 0; k < 3; k++) step();
    endtask

    task automatic test_long_press();
        int long_count = 0;
        for (int k = 0; k < 50; k++) begin
            btn_in = (k < 40);
            step();
            if (long_press === 1'b1) long_count++;
            checks++;
            if ({press, release_pulse, btn_level, long_press} !==
                {k == 5, k == 45, k >= 5 && k < 45, LongEn && k == 21}) begin
                errors++;
                $display("FAIL long_hold k=%0d got=%b want=%b", k,
                         {press, release_pulse, btn_level, long_press},
                         {k == 5, k == 45, k >= 5 && k < 45, LongEn && k == 21});
            end
        end
        checks++;
        if (long_count !== (LongEn ? 1 : 0)) begin
            errors++;
            $display("FAIL long_count got=%0d want=%0d", long_count, LongEn ? 1 : 0);
        end
        for (int k = 0; k < 30; k++) begin
            btn_in = (k < 10);
            step();
            checks++;
            if ({press, release_pulse, btn_level, long_press} !==
                {k == 5, k == 15, k >= 5 && k < 15, 1'b0}) begin
                errors++;
                $display("FAIL long_short k=%0d got=%b want=%b", k,
                         {press, release_pulse, btn_level, long_press},
                         {k == 5, k == 15, k >= 5 && k < 15, 1'b0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_latency();
        test_glitch();
        test_min_width();
        test_bounce();
        test_reset_mid_wait();
        test_long_press();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
